// File: rtl/ddr_data_port_pkg.sv
// Shared widths, burst lengths and FSM encoding for the DDR data port.
package ddr_port_pkg;

    localparam int DATA_WIDTH     = 16;
    localparam int DDR_ADDR_WIDTH = 28;
    localparam int BURST_LEN      = 16;
    localparam int JMP_LEN        = 2;
    localparam int CNT_W          = 10;
    localparam int PTR_W          = $clog2(BURST_LEN);

    localparam logic [CNT_W-1:0] BURST_LEN_W = CNT_W'(BURST_LEN);
    localparam logic [CNT_W-1:0] JMP_LEN_W   = CNT_W'(JMP_LEN);

    typedef enum logic [3:0] {
        ST_IDLE       = 4'd0,
        ST_RD_BURST   = 4'd1,
        ST_JMP_BURST  = 4'd2,
        ST_ST_CAPTURE = 4'd3,
        ST_WR_BURST   = 4'd4,
        ST_DONE       = 4'd5
    } state_t;

endpackage

// File: rtl/ddr_data_port_if.sv
// Cache-side request bus and DDR burst-controller bus of the data port.
interface ddr_data_port_if;
    import ddr_port_pkg::*;

    // Level requests are held by the cache; DDR strobes/pulses are single-cycle
    // and sampled on the rising clock edge.
    logic                      DATA_read_req;
    logic [DDR_ADDR_WIDTH-1:0] DATA_read_addr;
    logic                      DATA_store_req;
    logic [DDR_ADDR_WIDTH-1:0] DATA_write_addr;
    logic [DATA_WIDTH-1:0]     DATA_to_ddr;
    logic                      JMP_ADDR_read_req;
    logic [DATA_WIDTH-1:0]     DATA_to_cache;
    logic [CNT_W-1:0]          rd_cnt_data;
    logic                      rd_burst_data_valid;
    logic [DDR_ADDR_WIDTH-1:0] JMP_ADDR_to_cache;
    logic                      DATA_store_done;
    logic                      rd_burst_req;
    logic [CNT_W-1:0]          rd_burst_len;
    logic [DDR_ADDR_WIDTH-1:0] rd_burst_addr;
    logic [DATA_WIDTH-1:0]     rd_burst_data;
    logic                      rd_burst_data_valid_ddr;
    logic                      rd_burst_finish;
    logic                      wr_burst_req;
    logic [CNT_W-1:0]          wr_burst_len;
    logic [DDR_ADDR_WIDTH-1:0] wr_burst_addr;
    logic                      wr_burst_data_req;
    logic [DATA_WIDTH-1:0]     wr_burst_data;
    logic                      wr_burst_finish;
    logic [3:0]                dbg_state;

    modport slave (
        input  DATA_read_req, DATA_read_addr, DATA_store_req, DATA_write_addr,
               DATA_to_ddr, JMP_ADDR_read_req, rd_burst_data,
               rd_burst_data_valid_ddr, rd_burst_finish, wr_burst_data_req,
               wr_burst_finish,
        output DATA_to_cache, rd_cnt_data, rd_burst_data_valid, JMP_ADDR_to_cache,
               DATA_store_done, rd_burst_req, rd_burst_len, rd_burst_addr,
               wr_burst_req, wr_burst_len, wr_burst_addr, wr_burst_data, dbg_state
    );

    modport master (
        output DATA_read_req, DATA_read_addr, DATA_store_req, DATA_write_addr,
               DATA_to_ddr, JMP_ADDR_read_req, rd_burst_data,
               rd_burst_data_valid_ddr, rd_burst_finish, wr_burst_data_req,
               wr_burst_finish,
        input  DATA_to_cache, rd_cnt_data, rd_burst_data_valid, JMP_ADDR_to_cache,
               DATA_store_done, rd_burst_req, rd_burst_len, rd_burst_addr,
               wr_burst_req, wr_burst_len, wr_burst_addr, wr_burst_data, dbg_state
    );

endinterface

// File: rtl/ddr_store_buffer.sv
// Holds one store burst; filled during capture and drained by DDR pulls.
module ddr_store_buffer
    import ddr_port_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem_q [BURST_LEN];
    logic [DATA_WIDTH-1:0] mem_d [BURST_LEN];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(BURST_LEN - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        rd_data_d = rd_data_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (wr_en) begin
                mem_d[wr_ptr_q] = wr_data;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            // The popped word is registered so it appears the cycle after the pull.
            if (rd_en) begin
                rd_data_d = mem_q[rd_ptr_q];
                rd_ptr_d  = ptr_inc(rd_ptr_q);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BURST_LEN; i++) mem_q[i] <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            rd_data_q <= '0;
        end else begin
            mem_q     <= mem_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/ddr_data_port.sv
// DDR-side responder for the data cache: burst reads, jump-address reads and
// buffered store bursts, arbitrated store > read > jump in IDLE.
module ddr_data_port
    import ddr_port_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    ddr_data_port_if.slave  bus
);

    state_t                    state_q, state_d;
    logic [DDR_ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic [DDR_ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [PTR_W-1:0]          cap_cnt_q, cap_cnt_d;
    logic                      drop_q, drop_d;
    logic [DATA_WIDTH-1:0]     to_cache_q, to_cache_d;
    logic                      valid_q, valid_d;
    logic [DDR_ADDR_WIDTH-1:0] jmp_q, jmp_d;
    logic                      done_q, done_d;

    logic                      buf_clr, buf_wr, buf_rd;
    logic [DATA_WIDTH-1:0]     buf_wdata, buf_rdata;
    logic [CNT_W-1:0]          cur_len;

    ddr_store_buffer u_buf (
        .clk     (clk),
        .rst     (rst),
        .clr     (buf_clr),
        .wr_en   (buf_wr),
        .wr_data (buf_wdata),
        .rd_en   (buf_rd),
        .rd_data (buf_rdata)
    );

    assign cur_len = (state_q == ST_JMP_BURST) ? JMP_LEN_W : BURST_LEN_W;

    always_comb begin
        state_d    = state_q;
        rd_addr_d  = rd_addr_q;
        wr_addr_d  = wr_addr_q;
        cnt_d      = cnt_q;
        cap_cnt_d  = cap_cnt_q;
        drop_d     = drop_q;
        to_cache_d = to_cache_q;
        valid_d    = 1'b0;
        jmp_d      = jmp_q;
        done_d     = 1'b0;
        buf_clr    = 1'b0;
        buf_wr     = 1'b0;
        buf_wdata  = '0;
        buf_rd     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.DATA_store_req) begin
                    state_d   = ST_ST_CAPTURE;
                    wr_addr_d = bus.DATA_write_addr;
                    cap_cnt_d = '0;
                    drop_d    = 1'b0;
                    buf_clr   = 1'b1;
                end else if (bus.DATA_read_req) begin
                    state_d   = ST_RD_BURST;
                    rd_addr_d = bus.DATA_read_addr;
                    cnt_d     = '0;
                    buf_clr   = 1'b1;
                end else if (bus.JMP_ADDR_read_req) begin
                    state_d   = ST_JMP_BURST;
                    rd_addr_d = bus.DATA_read_addr;
                    cnt_d     = '0;
                    buf_clr   = 1'b1;
                end
            end

            ST_ST_CAPTURE: begin
                // Once the cache lets go of the request the rest of the burst is zero-padded.
                buf_wr    = 1'b1;
                drop_d    = drop_q | ~bus.DATA_store_req;
                buf_wdata = (bus.DATA_store_req && !drop_q) ? bus.DATA_to_ddr : '0;
                cap_cnt_d = cap_cnt_q + 1'b1;
                if (cap_cnt_q == PTR_W'(BURST_LEN - 1)) state_d = ST_WR_BURST;
            end

            ST_WR_BURST: begin
                buf_rd = bus.wr_burst_data_req;
                if (bus.wr_burst_finish) begin
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end
            end

            ST_RD_BURST, ST_JMP_BURST: begin
                if (bus.rd_burst_data_valid_ddr && (cnt_q < cur_len)) begin
                    to_cache_d = bus.rd_burst_data;
                    valid_d    = 1'b1;
                    cnt_d      = cnt_q + 1'b1;
                    if (state_q == ST_JMP_BURST) begin
                        if (cnt_q == '0)
                            jmp_d[DATA_WIDTH-1:0] = bus.rd_burst_data;
                        else
                            jmp_d[DDR_ADDR_WIDTH-1:DATA_WIDTH] =
                                bus.rd_burst_data[DDR_ADDR_WIDTH-DATA_WIDTH-1:0];
                    end
                end
                if (bus.rd_burst_finish) state_d = ST_DONE;
            end

            ST_DONE: begin
                // Level requests must all fall before a new one can be accepted.
                if (!bus.DATA_store_req && !bus.DATA_read_req && !bus.JMP_ADDR_read_req)
                    state_d = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            rd_addr_q  <= '0;
            wr_addr_q  <= '0;
            cnt_q      <= '0;
            cap_cnt_q  <= '0;
            drop_q     <= 1'b0;
            to_cache_q <= '0;
            valid_q    <= 1'b0;
            jmp_q      <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_addr_q  <= rd_addr_d;
            wr_addr_q  <= wr_addr_d;
            cnt_q      <= cnt_d;
            cap_cnt_q  <= cap_cnt_d;
            drop_q     <= drop_d;
            to_cache_q <= to_cache_d;
            valid_q    <= valid_d;
            jmp_q      <= jmp_d;
            done_q     <= done_d;
        end
    end

    assign bus.DATA_to_cache       = to_cache_q;
    assign bus.rd_cnt_data         = cnt_q;
    assign bus.rd_burst_data_valid = valid_q;
    assign bus.JMP_ADDR_to_cache   = jmp_q;
    assign bus.DATA_store_done     = done_q;
    assign bus.rd_burst_req        = (state_q == ST_RD_BURST) || (state_q == ST_JMP_BURST);
    assign bus.rd_burst_len        = (state_q == ST_RD_BURST)  ? BURST_LEN_W :
                                     (state_q == ST_JMP_BURST) ? JMP_LEN_W : '0;
    assign bus.rd_burst_addr       = rd_addr_q;
    assign bus.wr_burst_req        = (state_q == ST_WR_BURST);
    assign bus.wr_burst_len        = (state_q == ST_WR_BURST) ? BURST_LEN_W : '0;
    assign bus.wr_burst_addr       = wr_addr_q;
    assign bus.wr_burst_data       = buf_rdata;
    assign bus.dbg_state           = state_q;

endmodule

// File: tb/tb_ddr_data_port.sv
// Randomised bench for ddr_data_port with a behavioural cache/DDR model.
module tb_ddr_data_port;
  import ddr_port_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ddr_data_port_if bus();
  ddr_data_port dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;
  logic [DATA_WIDTH-1:0] exp_q[$];
  logic [DATA_WIDTH-1:0] stim[BURST_LEN];
  logic [DDR_ADDR_WIDTH-1:0] last_jmp;

  task automatic idle_inputs();
    bus.DATA_read_req = 0; bus.DATA_read_addr = '0;
    bus.DATA_store_req = 0; bus.DATA_write_addr = '0;
    bus.DATA_to_ddr = '0; bus.JMP_ADDR_read_req = 0;
    bus.rd_burst_data = '0; bus.rd_burst_data_valid_ddr = 0; bus.rd_burst_finish = 0;
    bus.wr_burst_data_req = 0; bus.wr_burst_finish = 0;
  endtask

  task automatic release_reqs();
    bus.DATA_read_req = 0; bus.DATA_store_req = 0; bus.JMP_ADDR_read_req = 0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic fill_random();
    for (int i = 0; i < BURST_LEN; i++) stim[i] = DATA_WIDTH'($urandom);
  endtask

  task automatic check_all_zero(input string tag);
    checks++;
    if (bus.rd_burst_req !== 0 || bus.wr_burst_req !== 0 || bus.DATA_store_done !== 0 ||
        bus.rd_burst_data_valid !== 0 || bus.DATA_to_cache !== 0 || bus.rd_cnt_data !== 0 ||
        bus.JMP_ADDR_to_cache !== 0 || bus.wr_burst_data !== 0 || bus.rd_burst_addr !== 0 ||
        bus.wr_burst_addr !== 0 || bus.rd_burst_len !== 0) begin
      errors++;
      $display("FAIL %s: outputs rd_req=%0b wr_req=%0b done=%0b vld=%0b data=%h cnt=%0d jmp=%h wdata=%h raddr=%h waddr=%h, required all 0",
               tag, bus.rd_burst_req, bus.wr_burst_req, bus.DATA_store_done, bus.rd_burst_data_valid,
               bus.DATA_to_cache, bus.rd_cnt_data, bus.JMP_ADDR_to_cache, bus.wr_burst_data,
               bus.rd_burst_addr, bus.wr_burst_addr);
    end
  endtask

  task automatic wait_rd_req(output bit ok);
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.rd_burst_req === 1'b1) begin ok = 1; break; end
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL rd_req_timeout: rd_burst_req=%0b, required 1", bus.rd_burst_req); end
  endtask

  // DDR read side: returns n words from stim (with random idle cycles), then
  // extra unwanted strobes, then the finish pulse.
  task automatic read_beats(input int n, input int extra, input logic [CNT_W-1:0] len);
    logic [DATA_WIDTH-1:0] w, e;
    logic [CNT_W-1:0] exp_cnt;
    exp_cnt = '0;
    exp_q.delete();
    for (int i = 0; i < n + extra; ) begin
      if ($urandom_range(0, 3) == 0) begin
        bus.rd_burst_data_valid_ddr = 0;
        bus.rd_burst_data = DATA_WIDTH'($urandom);
        @(negedge clk);
        checks++;
        if (bus.rd_burst_data_valid !== 0 || bus.rd_burst_req !== 1) begin
          errors++;
          $display("FAIL rd_gap: valid=%0b req=%0b, required valid 0 req 1", bus.rd_burst_data_valid, bus.rd_burst_req);
        end
      end else begin
        w = (i < n) ? stim[i] : DATA_WIDTH'($urandom);
        if (i < n) exp_q.push_back(w);
        bus.rd_burst_data_valid_ddr = 1;
        bus.rd_burst_data = w;
        @(negedge clk);
        bus.rd_burst_data_valid_ddr = 0;
        checks++;
        if (i < n) begin
          e = exp_q.pop_front();
          exp_cnt = exp_cnt + 1'b1;
          if (bus.rd_burst_data_valid !== 1 || bus.DATA_to_cache !== e || bus.rd_cnt_data !== exp_cnt) begin
            errors++;
            $display("FAIL rd_word%0d: valid=%0b data=%h cnt=%0d, required valid 1 data %h cnt %0d",
                     i, bus.rd_burst_data_valid, bus.DATA_to_cache, bus.rd_cnt_data, e, exp_cnt);
          end
        end else if (bus.rd_burst_data_valid !== 0 || bus.rd_cnt_data !== len) begin
          errors++;
          $display("FAIL rd_saturate: valid=%0b cnt=%0d, required valid 0 cnt %0d",
                   bus.rd_burst_data_valid, bus.rd_cnt_data, len);
        end
        i++;
      end
    end
    bus.rd_burst_finish = 1;
    @(negedge clk);
    bus.rd_burst_finish = 0;
    checks++;
    if (bus.rd_burst_req !== 0 || bus.rd_cnt_data !== len) begin
      errors++;
      $display("FAIL rd_finish: rd_burst_req=%0b cnt=%0d, required 0 and %0d", bus.rd_burst_req, bus.rd_cnt_data, len);
    end
  endtask

  task automatic run_read(input logic [DDR_ADDR_WIDTH-1:0] addr, input int extra);
    bit ok;
    bus.DATA_read_addr = addr;
    bus.DATA_read_req = 1;
    wait_rd_req(ok);
    if (!ok) return;
    checks++;
    if (bus.rd_burst_addr !== addr || bus.rd_burst_len !== BURST_LEN_W || bus.rd_cnt_data !== 0 ||
        bus.wr_burst_req !== 0) begin
      errors++;
      $display("FAIL rd_start: addr=%h len=%0d cnt=%0d wr_req=%0b, required addr %h len %0d cnt 0 wr_req 0",
               bus.rd_burst_addr, bus.rd_burst_len, bus.rd_cnt_data, bus.wr_burst_req, addr, BURST_LEN);
    end
    read_beats(BURST_LEN, extra, BURST_LEN_W);
  endtask

  task automatic run_jmp(input logic [DDR_ADDR_WIDTH-1:0] addr, input int extra);
    bit ok;
    logic [DDR_ADDR_WIDTH-1:0] exp_jmp;
    logic [DATA_WIDTH-1:0] hi;
    hi = stim[1];
    exp_jmp = {hi[DDR_ADDR_WIDTH-DATA_WIDTH-1:0], stim[0]};
    bus.DATA_read_addr = addr;
    bus.JMP_ADDR_read_req = 1;
    wait_rd_req(ok);
    if (!ok) return;
    checks++;
    if (bus.rd_burst_addr !== addr || bus.rd_burst_len !== JMP_LEN_W) begin
      errors++;
      $display("FAIL jmp_start: addr=%h len=%0d, required addr %h len %0d", bus.rd_burst_addr, bus.rd_burst_len, addr, JMP_LEN);
    end
    read_beats(JMP_LEN, extra, JMP_LEN_W);
    release_reqs();
    checks++;
    if (bus.JMP_ADDR_to_cache !== exp_jmp || bus.rd_cnt_data !== JMP_LEN_W) begin
      errors++;
      $display("FAIL jmp_addr: jmp=%h cnt=%0d, required jmp %h cnt %0d", bus.JMP_ADDR_to_cache, bus.rd_cnt_data, exp_jmp, JMP_LEN);
    end
    last_jmp = exp_jmp;
  endtask

  // Cache streams stim into the port (zeros expected from drop_at on), then the
  // DDR model pulls n_pull words; a full pull is followed by the finish pulse.
  task automatic run_store(input logic [DDR_ADDR_WIDTH-1:0] addr, input int drop_at, input int n_pull);
    logic [DATA_WIDTH-1:0] e;
    bit rd_seen, ok, fire;
    int pulled, guard;
    rd_seen = 0;
    exp_q.delete();
    bus.DATA_write_addr = addr;
    bus.DATA_store_req = 1;
    bus.DATA_to_ddr = DATA_WIDTH'($urandom);
    @(negedge clk);
    for (int i = 0; i < BURST_LEN; i++) begin
      if (i >= drop_at) begin
        bus.DATA_store_req = 0;
        bus.DATA_to_ddr = DATA_WIDTH'($urandom);
        exp_q.push_back('0);
      end else begin
        bus.DATA_to_ddr = stim[i];
        exp_q.push_back(stim[i]);
      end
      @(negedge clk);
      if (bus.rd_burst_req !== 0) rd_seen = 1;
    end
    checks++;
    if (rd_seen) begin errors++; $display("FAIL st_capture_rd: rd_burst_req=1 during capture, required 0"); end
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.wr_burst_req === 1'b1) begin ok = 1; break; end
      @(negedge clk);
    end
    checks++;
    if (!ok || bus.wr_burst_addr !== addr || bus.wr_burst_len !== BURST_LEN_W || bus.rd_burst_req !== 0) begin
      errors++;
      $display("FAIL wr_start: req=%0b addr=%h len=%0d rd_req=%0b, required req 1 addr %h len %0d rd_req 0",
               bus.wr_burst_req, bus.wr_burst_addr, bus.wr_burst_len, bus.rd_burst_req, addr, BURST_LEN);
      return;
    end
    pulled = 0;
    guard = 0;
    while (pulled < n_pull && guard < 200) begin
      fire = ($urandom_range(0, 3) != 0);
      bus.wr_burst_data_req = fire;
      @(negedge clk);
      bus.wr_burst_data_req = 0;
      guard++;
      if (fire) begin
        e = exp_q.pop_front();
        checks++;
        if (bus.wr_burst_data !== e) begin
          errors++;
          $display("FAIL wr_word%0d: data=%h, required %h", pulled, bus.wr_burst_data, e);
        end
        pulled++;
      end
    end
    checks++;
    if (pulled != n_pull) begin errors++; $display("FAIL wr_pull_budget: pulled %0d, required %0d", pulled, n_pull); end
    if (n_pull < BURST_LEN) return;
    bus.wr_burst_finish = 1;
    @(negedge clk);
    bus.wr_burst_finish = 0;
    checks++;
    if (bus.DATA_store_done !== 1 || bus.wr_burst_req !== 0) begin
      errors++;
      $display("FAIL store_done: done=%0b wr_req=%0b, required done 1 wr_req 0", bus.DATA_store_done, bus.wr_burst_req);
    end
    @(negedge clk);
    checks++;
    if (bus.DATA_store_done !== 0) begin
      errors++;
      $display("FAIL store_done_pulse: done=%0b one cycle later, required 0", bus.DATA_store_done);
    end
    bus.DATA_store_req = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    repeat (3) @(negedge clk);
    check_all_zero("reset_state");
    rst = 0;
    @(negedge clk);
    check_all_zero("after_reset_idle");
  endtask

  task automatic test_read_directed();
    for (int i = 0; i < BURST_LEN; i++) stim[i] = 16'hA000 + 16'(i);
    run_read(28'h0000100, 0);
  endtask

  task automatic test_held_req();
    bit bad;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.rd_burst_req !== 0 || bus.wr_burst_req !== 0) bad = 1;
    end
    checks++;
    if (bad) begin errors++; $display("FAIL held_req: a second burst started while the request stayed high, required none"); end
    release_reqs();
    checks++;
    if (bus.rd_cnt_data !== BURST_LEN_W) begin
      errors++;
      $display("FAIL cnt_hold: cnt=%0d in idle, required %0d", bus.rd_cnt_data, BURST_LEN);
    end
  endtask

  task automatic test_read_random();
    for (int k = 0; k < 2; k++) begin
      fill_random();
      run_read(DDR_ADDR_WIDTH'($urandom), $urandom_range(1, 3));
      release_reqs();
    end
  endtask

  task automatic test_store_directed();
    for (int i = 0; i < BURST_LEN; i++) stim[i] = 16'(i + 1);
    run_store(28'h0005000, BURST_LEN, BURST_LEN);
    release_reqs();
  endtask

  task automatic test_store_drop();
    fill_random();
    run_store(DDR_ADDR_WIDTH'($urandom), $urandom_range(4, 12), BURST_LEN);
    release_reqs();
  endtask

  task automatic test_jmp();
    stim[0] = 16'h3456;
    stim[1] = 16'h0012;
    run_jmp(28'h0000200, 0);
    fill_random();
    run_jmp(DDR_ADDR_WIDTH'($urandom), 1);
  endtask

  task automatic test_priority();
    bit bad;
    bus.DATA_read_addr = 28'h0000300;
    bus.DATA_read_req = 1;
    bus.JMP_ADDR_read_req = 1;
    fill_random();
    run_store(DDR_ADDR_WIDTH'($urandom), BURST_LEN, BURST_LEN);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.rd_burst_req !== 0 || bus.wr_burst_req !== 0) bad = 1;
    end
    checks++;
    if (bad) begin errors++; $display("FAIL priority_hold: burst started before requests dropped, required none"); end
    release_reqs();
    fill_random();
    run_read(DDR_ADDR_WIDTH'($urandom), 0);
    release_reqs();
    checks++;
    if (bus.JMP_ADDR_to_cache !== last_jmp) begin
      errors++;
      $display("FAIL jmp_hold: jmp=%h after a read, required %h", bus.JMP_ADDR_to_cache, last_jmp);
    end
  endtask

  task automatic test_reset_mid_write();
    fill_random();
    run_store(DDR_ADDR_WIDTH'($urandom), BURST_LEN, 5);
    rst = 1;
    idle_inputs();
    @(posedge clk);
    #1;
    check_all_zero("reset_mid_write");
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    fill_random();
    run_read(DDR_ADDR_WIDTH'($urandom), 0);
    release_reqs();
  endtask

  initial begin
    last_jmp = '0;
    test_reset();
    test_read_directed();
    test_held_req();
    test_read_random();
    test_store_directed();
    test_store_drop();
    test_jmp();
    test_priority();
    test_reset_mid_write();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
